// File: rtl/color_sequencer_pkg.sv
// Shared colour codes, sequence FSM states and the flag encoder
// for the colour sequencer.
package color_sequencer_pkg;

  localparam logic [2:0] C_NONE   = 3'd0;
  localparam logic [2:0] C_RED    = 3'd1;
  localparam logic [2:0] C_GREEN  = 3'd2;
  localparam logic [2:0] C_BLUE   = 3'd3;
  localparam logic [2:0] C_PURPLE = 3'd4;
  localparam logic [2:0] C_YELLOW = 3'd5;
  localparam logic [2:0] C_MULTI  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } seq_state_e;

  // f = {yellow, purple, blue, green, red}
  function automatic logic [2:0] encode(input logic [4:0] f);
    logic [2:0] c;
    case (f)
      5'b00000: c = C_NONE;
      5'b00001: c = C_RED;
      5'b00010: c = C_GREEN;
      5'b00100: c = C_BLUE;
      5'b01000: c = C_PURPLE;
      5'b10000: c = C_YELLOW;
      default:  c = C_MULTI;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/color_stabilizer.sv
// Registers and encodes the comparator flags, then debounces them
// into an accepted colour code with a one-cycle valid pulse.
import color_sequencer_pkg::*;

module color_stabilizer #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       red,
  input  logic       green,
  input  logic       blue,
  input  logic       purple,
  input  logic       yellow,
  input  logic       clear,
  output logic [2:0] color_code,
  output logic       color_valid,
  output logic       conflict,
  output logic       accept,
  output logic [2:0] acc_code
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

  logic [2:0] s_q;
  logic [2:0] cand_q;
  logic [7:0] cnt_q;
  logic [2:0] code_q;
  logic       valid_q;
  logic       stable;
  logic       hit_none;

  assign stable   = (s_q == cand_q) && (cnt_q == CNT_HIT);
  assign accept   = stable && !clear && (s_q != C_NONE)
                    && (s_q != C_MULTI) && (s_q != code_q);
  assign hit_none = stable && !clear && (s_q == C_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= C_NONE;
    end else begin
      s_q <= encode({yellow, purple, blue, green, red});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q  <= C_NONE;
      cnt_q   <= 8'd0;
      code_q  <= C_NONE;
      valid_q <= 1'b0;
    end else if (clear) begin
      cand_q  <= C_NONE;
      cnt_q   <= 8'd0;
      code_q  <= C_NONE;
      valid_q <= 1'b0;
    end else begin
      if (s_q != cand_q) begin
        cand_q <= s_q;
        cnt_q  <= 8'd1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 8'd1;
      end
      // settling on none re-arms acceptance of the previous colour
      if (accept) begin
        code_q <= s_q;
      end else if (hit_none) begin
        code_q <= C_NONE;
      end
      valid_q <= accept;
    end
  end

  assign acc_code    = s_q;
  assign color_code  = code_q;
  assign color_valid = valid_q;
  assign conflict    = (s_q == C_MULTI);

endmodule

// File: rtl/color_sequencer.sv
// Debounced colour acceptance plus matching against a programmed
// colour sequence with lock and mismatch indications.
import color_sequencer_pkg::*;

module color_sequencer #(
  parameter int STABLE_CYCLES = 4,
  parameter int SEQ_LEN       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       red,
  input  logic                       green,
  input  logic                       blue,
  input  logic                       purple,
  input  logic                       yellow,
  input  logic [3*SEQ_LEN-1:0]       seq_code,
  input  logic                       clear,
  output logic [2:0]                 color_code,
  output logic                       color_valid,
  output logic                       conflict,
  output logic [$clog2(SEQ_LEN)-1:0] seq_pos,
  output logic                       seq_fail,
  output logic                       locked
);

  localparam int PW = $clog2(SEQ_LEN);
  localparam logic [PW-1:0] LAST = PW'(SEQ_LEN - 1);

  logic          accept;
  logic [2:0]    acc_code;
  seq_state_e    state_q;
  seq_state_e    state_d;
  logic [PW-1:0] pos_q;
  logic [PW-1:0] pos_d;
  logic          fail_q;
  logic          fail_d;
  logic [2:0]    slot_cur;
  logic [2:0]    slot_first;

  color_stabilizer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .clk         (clk),
    .rst_n       (rst_n),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .purple      (purple),
    .yellow      (yellow),
    .clear       (clear),
    .color_code  (color_code),
    .color_valid (color_valid),
    .conflict    (conflict),
    .accept      (accept),
    .acc_code    (acc_code)
  );

  assign slot_cur   = seq_code[3*int'(pos_q) +: 3];
  assign slot_first = seq_code[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    fail_d  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      pos_d   = '0;
    end else if (accept && state_q != S_LOCKED) begin
      if (acc_code == slot_cur) begin
        if (pos_q == LAST) begin
          state_d = S_LOCKED;
          pos_d   = '0;
        end else begin
          state_d = S_TRACK;
          pos_d   = pos_q + PW'(1);
        end
      end else begin
        // a wrong colour may still be the start of a fresh attempt
        fail_d = 1'b1;
        if (acc_code == slot_first) begin
          state_d = S_TRACK;
          pos_d   = PW'(1);
        end else begin
          state_d = S_IDLE;
          pos_d   = '0;
        end
      end
    end
  end

  always_comb begin
    locked   = (state_q == S_LOCKED);
    seq_pos  = pos_q;
    seq_fail = fail_q;
  end

endmodule

// File: tb/tb_color_sequencer.sv
// Directed and randomized checks of color_sequencer against a
// run-length based reference model.
module tb_color_sequencer;

  localparam int STB = 4;
  localparam int L   = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           red, green, blue, purple, yellow, clear;
  logic [3*L-1:0] seq_code;
  logic [2:0]     color_code;
  logic           color_valid, conflict, seq_fail, locked;
  logic [1:0]     seq_pos;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;

  int m_s, m_prev, m_run, m_code, m_pos;
  bit m_valid, m_fail, m_locked;

  color_sequencer #(.STABLE_CYCLES(STB), .SEQ_LEN(L)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .purple      (purple),
    .yellow      (yellow),
    .seq_code    (seq_code),
    .clear       (clear),
    .color_code  (color_code),
    .color_valid (color_valid),
    .conflict    (conflict),
    .seq_pos     (seq_pos),
    .seq_fail    (seq_fail),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int enc(logic [4:0] f);
    if ($countones(f) == 0) return 0;
    if ($countones(f) > 1) return 7;
    for (int i = 0; i < 5; i++) if (f[i]) return i + 1;
    return 0;
  endfunction

  function automatic int slot(int i);
    logic [2:0] v;
    v = seq_code[3*i +: 3];
    return int'(v);
  endfunction

  function automatic logic [4:0] hot(int c);
    logic [4:0] one;
    one = 5'b00001;
    return (c == 0) ? 5'b00000 : (one << (c - 1));
  endfunction

  task automatic model_reset();
    m_s = 0; m_prev = 0; m_run = 0; m_code = 0; m_pos = 0;
    m_valid = 0; m_fail = 0; m_locked = 0;
  endtask

  // a colour is taken the moment its run of sampled codes reaches STB
  task automatic model_edge(logic [4:0] f, logic clr);
    int obs;
    bit acc;
    obs = m_s;
    if (clr) begin
      m_prev = 0; m_run = 0; m_code = 0; m_pos = 0;
      m_valid = 0; m_fail = 0; m_locked = 0;
    end else begin
      if (obs == m_prev) m_run++;
      else begin
        m_prev = obs;
        m_run = 1;
      end
      acc = (m_run == STB) && obs != 0 && obs != 7 && obs != m_code;
      m_valid = acc;
      m_fail = 0;
      if (acc) begin
        m_code = obs;
        if (!m_locked) begin
          if (obs == slot(m_pos)) begin
            if (m_pos == L - 1) begin
              m_locked = 1;
              m_pos = 0;
            end else m_pos++;
          end else begin
            m_fail = 1;
            m_pos = (obs == slot(0)) ? 1 : 0;
          end
        end
      end else if (m_run == STB && obs == 0) begin
        m_code = 0;
      end
    end
    m_s = enc(f);
  endtask

  task automatic check_all();
    chk("color_code", 8'(color_code), 8'(m_code));
    chk("color_valid", 8'(color_valid), 8'(m_valid));
    chk("conflict", 8'(conflict), 8'(m_s == 7));
    chk("seq_pos", 8'(seq_pos), 8'(m_pos));
    chk("seq_fail", 8'(seq_fail), 8'(m_fail));
    chk("locked", 8'(locked), 8'(m_locked));
  endtask

  task automatic tick(logic [4:0] f, logic clr = 1'b0);
    {yellow, purple, blue, green, red} = f;
    clear = clr;
    @(posedge clk);
    model_edge(f, clr);
    #1;
    check_all();
    if (color_valid) n_pulse++;
  endtask

  task automatic hold(int c, int n);
    repeat (n) tick(hot(c));
  endtask

  initial begin
    logic [4:0] f;
    int c, n;
    {yellow, purple, blue, green, red} = 5'b0;
    clear = 1'b0;
    seq_code = {3'd5, 3'd3, 3'd2, 3'd1};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // debounce latency from reset release
    n_pulse = 0;
    hold(1, 10);
    chk("red_pulses", 8'(n_pulse), 8'd1);
    chk("red_code", 8'(color_code), 8'd1);
    hold(0, 6);

    // glitch restarts the window
    n_pulse = 0;
    hold(2, 3);
    hold(0, 1);
    hold(2, 3);
    chk("glitch_early", 8'(n_pulse), 8'd0);
    hold(2, 4);
    chk("glitch_pulses", 8'(n_pulse), 8'd1);
    chk("glitch_code", 8'(color_code), 8'd2);

    // multi-hot never accepted
    n_pulse = 0;
    repeat (10) tick(5'b10001);
    chk("multi_pulses", 8'(n_pulse), 8'd0);
    chk("multi_conflict", 8'(conflict), 8'd1);
    hold(0, 6);

    // full match then an extra colour while locked
    tick(5'b0, 1'b1);
    foreach (seq_code[i]) if (i < 0) $finish;
    c = 0;
    for (int k = 0; k < L; k++) begin
      hold(slot(k), 6);
      hold(0, 6);
    end
    chk("full_locked", 8'(locked), 8'd1);
    chk("full_pos", 8'(seq_pos), 8'd0);
    hold(4, 6);
    chk("locked_purple", 8'(color_code), 8'd4);
    hold(0, 6);

    // mismatch restarts on first slot
    tick(5'b0, 1'b1);
    hold(1, 6); hold(0, 6);
    hold(2, 6); hold(0, 6);
    hold(1, 6);
    chk("restart_pos", 8'(seq_pos), 8'd1);
    hold(0, 6);
    hold(2, 6); hold(0, 6);
    hold(3, 6); hold(0, 6);
    hold(5, 6); hold(0, 6);
    chk("restart_locked", 8'(locked), 8'd1);

    // clear on the accept edge
    tick(5'b0, 1'b1);
    hold(1, 4);
    tick(hot(1), 1'b1);
    chk("clr_valid", 8'(color_valid), 8'd0);
    chk("clr_code", 8'(color_code), 8'd0);
    hold(0, 6);

    // randomized segments
    for (int seg = 0; seg < 80; seg++) begin
      c = $urandom_range(0, 9);
      if (c >= 6 && c <= 7) f = hot(slot(m_pos) % 6);
      else if (c == 8) f = hot($urandom_range(1, 5)) | hot($urandom_range(1, 5));
      else if (c == 9) f = 5'b0;
      else f = hot(c);
      n = $urandom_range(1, 7);
      for (int t = 0; t < n; t++) begin
        if ($urandom_range(0, 39) == 0) begin
          seq_code = 12'($urandom);
          for (int k = 0; k < L; k++)
            seq_code[3*k +: 3] = 3'($urandom_range(1, 5));
          tick(f, 1'b1);
        end else tick(f);
      end
    end

    // asynchronous reset mid-sequence
    tick(5'b0, 1'b1);
    seq_code = {3'd5, 3'd3, 3'd2, 3'd1};
    hold(1, 6); hold(0, 6);
    hold(2, 6); hold(0, 2);
    hold(3, 2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    hold(3, 8);
    hold(0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
